// File: rtl/compare_result_qualifier_if.sv
// Bundle between the magnitude comparator and its result qualifier:
// one per-sample Equal/Greater/Lesser result in, the debounced decision out.
interface compare_result_qualifier_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             equal;
  logic             greater;
  logic             lesser;
  logic             stable_valid;
  logic             stable_eq;
  logic             stable_gt;
  logic             stable_lt;
  logic             change;
  logic             onehot_err;
  logic [CNT_W-1:0] change_count;

  modport master (
    output in_valid, equal, greater, lesser,
    input  stable_valid, stable_eq, stable_gt, stable_lt,
    input  change, onehot_err, change_count
  );

  modport slave (
    input  in_valid, equal, greater, lesser,
    output stable_valid, stable_eq, stable_gt, stable_lt,
    output change, onehot_err, change_count
  );
endinterface

// File: rtl/compare_result_qualifier.sv
// Glitch filter for comparator results: commits a decision only after STABLE_CNT
// consecutive identical one-hot samples, flags malformed samples, counts commits.
module compare_result_qualifier #(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  compare_result_qualifier_if.slave   bus
);

  localparam int               RUN_W   = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ACQ     = 2'd0,
    HOLD_EQ = 2'd1,
    HOLD_GT = 2'd2,
    HOLD_LT = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [2:0] v);
    case (v)
      3'b100, 3'b010, 3'b001: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic state_t hold_of(input logic [2:0] v);
    case (v)
      3'b100:  return HOLD_EQ;
      3'b010:  return HOLD_GT;
      3'b001:  return HOLD_LT;
      default: return ACQ;
    endcase
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  state_t           target_s;
  logic [2:0]       sample_s;
  logic [2:0]       cand_r;
  logic [2:0]       cand_next_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;
  logic             commit_s;
  logic             bad_s;

  logic             stable_valid_r;
  logic             stable_eq_r;
  logic             stable_gt_r;
  logic             stable_lt_r;
  logic             change_r;
  logic             onehot_err_r;
  logic [CNT_W-1:0] count_r;

  // Run tracking, malformed-sample detection and next-state selection
  always_comb begin
    sample_s     = {bus.equal, bus.greater, bus.lesser};
    target_s     = hold_of(sample_s);
    cand_next_s  = cand_r;
    run_next_s   = run_r;
    commit_s     = 1'b0;
    bad_s        = 1'b0;
    state_next_s = state_r;
    if (bus.in_valid) begin
      if (is_onehot(sample_s)) begin
        cand_next_s = sample_s;
        if (sample_s == cand_r) begin
          if (run_r >= RUN_MAX) begin
            run_next_s = RUN_MAX;
          end else begin
            run_next_s = run_r + RUN_W'(1);
          end
        end else begin
          run_next_s = RUN_W'(1);
        end
        // a run that re-confirms the held decision is not a commit
        if ((run_next_s >= RUN_MAX) && (state_r != target_s)) begin
          commit_s     = 1'b1;
          state_next_s = target_s;
        end else begin
          commit_s     = 1'b0;
          state_next_s = state_r;
        end
      end else begin
        bad_s       = 1'b1;
        cand_next_s = 3'b000;
        run_next_s  = RUN_W'(0);
      end
    end else begin
      cand_next_s = cand_r;
      run_next_s  = run_r;
    end
  end

  // Decision state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Candidate/run history, registered outputs and saturating change counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_r         <= 3'b000;
      run_r          <= RUN_W'(0);
      stable_valid_r <= 1'b0;
      stable_eq_r    <= 1'b0;
      stable_gt_r    <= 1'b0;
      stable_lt_r    <= 1'b0;
      change_r       <= 1'b0;
      onehot_err_r   <= 1'b0;
      count_r        <= CNT_W'(0);
    end else begin
      cand_r         <= cand_next_s;
      run_r          <= run_next_s;
      stable_valid_r <= (state_next_s != ACQ);
      stable_eq_r    <= (state_next_s == HOLD_EQ);
      stable_gt_r    <= (state_next_s == HOLD_GT);
      stable_lt_r    <= (state_next_s == HOLD_LT);
      change_r       <= commit_s;
      onehot_err_r   <= bad_s;
      if (commit_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.stable_valid = stable_valid_r;
  assign bus.stable_eq    = stable_eq_r;
  assign bus.stable_gt    = stable_gt_r;
  assign bus.stable_lt    = stable_lt_r;
  assign bus.change       = change_r;
  assign bus.onehot_err   = onehot_err_r;
  assign bus.change_count = count_r;

endmodule
